// File: rtl/qam_slicer.sv
// -----------------------------------------------------------------------------
// qam_slicer
//   Hard-decision slicer for square M-QAM. Each accepted I/Q soft-sample pair
//   is sliced per axis to the nearest constellation level, Gray-mapped, packed
//   into a log2(M)-bit symbol word {g_i, g_q} and shifted out MSB first, one
//   bit per clock. A new pair can be accepted on the last-bit cycle, so
//   symbols stream with no gap in o_dv.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   i_dv         input sample valid
//   i_sample_i   in-phase soft sample, two's complement
//   i_sample_q   quadrature soft sample, two's complement
//   o_ready      block accepts a sample this cycle
//   o_bit        serial hard-decision bit (0 when o_dv is low)
//   o_dv         o_bit is valid
//   o_sos        start of symbol, high with the first bit of each symbol
//   o_overflow   sticky: a sample arrived while o_ready was low and was lost
// -----------------------------------------------------------------------------
module qam_slicer #(
  parameter int MODULATION_ORDER = 16,
  parameter int SAMPLE_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_dv,
  input  logic [SAMPLE_WIDTH-1:0] i_sample_i,
  input  logic [SAMPLE_WIDTH-1:0] i_sample_q,
  output logic                    o_ready,
  output logic                    o_bit,
  output logic                    o_dv,
  output logic                    o_sos,
  output logic                    o_overflow
);

  localparam int SYM_BITS  = $clog2(MODULATION_ORDER);
  localparam int AXIS_BITS = SYM_BITS / 2;
  localparam int L         = 1 << AXIS_BITS;
  localparam int CNT_W     = (SYM_BITS > 2) ? $clog2(SYM_BITS) : 1;
  localparam int SUM_W     = SAMPLE_WIDTH + 2;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SYM_BITS - 1);
  localparam logic signed [SUM_W-1:0] SUM_L    = SUM_W'(L);
  localparam logic signed [SUM_W-1:0] K_MAX    = SUM_W'(L - 1);

  // Slice one axis: k = clamp(floor((x + L) / 2), 0, L-1). The sum is taken
  // two bits wider than the sample so the sample extremes cannot wrap, and
  // the arithmetic shift gives floor division for negative sums.
  function automatic logic [AXIS_BITS-1:0] slice_axis(
    input logic signed [SAMPLE_WIDTH-1:0] x
  );
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] k;
    sum = {{2{x[SAMPLE_WIDTH-1]}}, x} + SUM_L;
    k   = sum >>> 1;
    if (k[SUM_W-1])
      slice_axis = '0;
    else if (k > K_MAX)
      slice_axis = '1;
    else
      slice_axis = k[AXIS_BITS-1:0];
  endfunction

  function automatic logic [AXIS_BITS-1:0] gray_map(
    input logic [AXIS_BITS-1:0] k
  );
    gray_map = k ^ (k >> 1);
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [SYM_BITS-1:0]        r_sym;
  logic                       r_bit;
  logic                       r_dv;
  logic                       r_sos;
  logic                       r_overflow;

  logic signed [SAMPLE_WIDTH-1:0] w_si;
  logic signed [SAMPLE_WIDTH-1:0] w_sq;
  logic [SYM_BITS-1:0]            w_word;
  logic                           w_last;
  logic                           w_accept;

  assign w_si     = i_sample_i;
  assign w_sq     = i_sample_q;
  assign w_word   = {gray_map(slice_axis(w_si)), gray_map(slice_axis(w_sq))};
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_LAST);
  assign o_ready  = (r_state == IDLE) || w_last;
  assign w_accept = i_dv && o_ready;

  // r_sym holds the bits still to be sent, left-aligned; r_bit is the bit on
  // the wire this cycle, so the MSB goes straight to r_bit at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sym      <= '0;
      r_bit      <= 1'b0;
      r_dv       <= 1'b0;
      r_sos      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (i_dv && !o_ready)
        r_overflow <= 1'b1;

      if (w_accept) begin
        r_state <= SHIFT;
        r_cnt   <= '0;
        r_bit   <= w_word[SYM_BITS-1];
        r_sym   <= {w_word[SYM_BITS-2:0], 1'b0};
        r_dv    <= 1'b1;
        r_sos   <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_sos <= 1'b0;
        if (w_last) begin
          r_state <= IDLE;
          r_dv    <= 1'b0;
          r_bit   <= 1'b0;
          r_sym   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_bit <= r_sym[SYM_BITS-1];
          r_sym <= {r_sym[SYM_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign o_bit      = r_bit;
  assign o_dv       = r_dv;
  assign o_sos      = r_sos;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_qam_slicer.sv
module tb_qam_slicer;

  logic clk = 1'b0;
  logic rst;

  // M = 16 instance
  logic              dv;
  logic signed [7:0] si, sq;
  logic              ready, obit, odv, sos, ovf;

  // M = 4 instance
  logic              dv4;
  logic signed [7:0] si4, sq4;
  logic              ready4, obit4, odv4, sos4, ovf4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  qam_slicer #(.MODULATION_ORDER(16), .SAMPLE_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .i_dv(dv), .i_sample_i(si), .i_sample_q(sq),
    .o_ready(ready), .o_bit(obit), .o_dv(odv), .o_sos(sos), .o_overflow(ovf)
  );

  qam_slicer #(.MODULATION_ORDER(4), .SAMPLE_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .i_dv(dv4), .i_sample_i(si4), .i_sample_q(sq4),
    .o_ready(ready4), .o_bit(obit4), .o_dv(odv4), .o_sos(sos4), .o_overflow(ovf4)
  );

  // ---------------- reference model ----------------
  function automatic int ref_k(int x, int lv);
    int t, k;
    t = x + lv;
    k = (t >= 0) ? t / 2 : -((1 - t) / 2);   // floor(t/2)
    if (k < 0) k = 0;
    if (k > lv - 1) k = lv - 1;
    return k;
  endfunction

  function automatic int ref_word(int xi, int xq, int lv);
    int ki, kq;
    ki = ref_k(xi, lv);
    kq = ref_k(xq, lv);
    return ((ki ^ (ki >> 1)) * lv) + (kq ^ (kq >> 1));
  endfunction

  function automatic logic ref_bit(int word, int nbits, int b);
    return ((word >> (nbits - 1 - b)) & 1) != 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic accept16(input int i, input int q);
    @(negedge clk);
    dv = 1'b1; si = 8'(i); sq = 8'(q);
    @(posedge clk);
    #1 dv = 1'b0;
  endtask

  task automatic accept4(input int i, input int q);
    @(negedge clk);
    dv4 = 1'b1; si4 = 8'(i); sq4 = 8'(q);
    @(posedge clk);
    #1 dv4 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; dv = 1'b0; si = '0; sq = '0; dv4 = 1'b0; si4 = '0; sq4 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({odv, obit, sos, ovf, ready} !== 5'b00001)
      $display("FAIL reset_outputs: dv/bit/sos/ovf/ready got %b want 00001", {odv, obit, sos, ovf, ready});
    else n_pass++;
    n_checks++;
    if ({odv4, obit4, sos4, ovf4, ready4} !== 5'b00001)
      $display("FAIL reset_outputs_m4: got %b want 00001", {odv4, obit4, sos4, ovf4, ready4});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [3:0] exp = 4'b1000;
    accept16(3, -3);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_checks++;
      if ({odv, obit, sos} !== {1'b1, exp[3-b], (b == 0)})
        $display("FAIL basic_bit%0d: dv/bit/sos got %b want %b", b, {odv, obit, sos}, {1'b1, exp[3-b], (b == 0)});
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({odv, obit, ready} !== 3'b001)
      $display("FAIL basic_idle: dv/bit/ready got %b want 001", {odv, obit, ready});
    else n_pass++;
  endtask

  task automatic test_thresholds;
    int         xs [6] = '{-3, -2, 0, 1, 127, -128};
    logic [1:0] gs [6] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [3:0] exp;
    for (int j = 0; j < 6; j++) begin
      exp = {gs[j], 2'b11};   // Q = 0 slices to k=2, Gray 11
      accept16(xs[j], 0);
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        n_checks++;
        if ({odv, obit} !== {1'b1, exp[3-b]})
          $display("FAIL thresh_I%0d_bit%0d: dv/bit got %b want %b", xs[j], b, {odv, obit}, {1'b1, exp[3-b]});
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp = 8'b1010_0000;
    accept16(3, 3);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({odv, obit, sos} !== {1'b1, exp[7-c], (c == 0 || c == 4)})
        $display("FAIL b2b_cycle%0d: dv/bit/sos got %b want %b", c, {odv, obit, sos}, {1'b1, exp[7-c], (c == 0 || c == 4)});
      else n_pass++;
      if (c == 1 || c == 3) begin
        n_checks++;
        if (ready !== (c == 3))
          $display("FAIL b2b_ready%0d: got %b want %b", c, ready, (c == 3));
        else n_pass++;
      end
      if (c == 3) begin dv = 1'b1; si = -3; sq = -3; end
      if (c == 4) dv = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({odv, ovf} !== 2'b00)
      $display("FAIL b2b_end: dv/ovf got %b want 00", {odv, ovf});
    else n_pass++;
  endtask

  task automatic test_random;
    int xi, xq, w;
    for (int n = 0; n < 24; n++) begin
      xi = $signed(8'($urandom));
      xq = $signed(8'($urandom));
      if (n % 6 == 0) xi = -128;
      if (n % 6 == 1) xq = 127;
      if (n % 4 == 2) begin xi = int'($urandom_range(0, 10)) - 5; xq = int'($urandom_range(0, 10)) - 5; end
      w = ref_word(xi, xq, 4);
      accept16(xi, xq);
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        n_checks++;
        if ({odv, obit, sos} !== {1'b1, ref_bit(w, 4, b), (b == 0)})
          $display("FAIL rand_I%0d_Q%0d_bit%0d: dv/bit/sos got %b want %b", xi, xq, b, {odv, obit, sos}, {1'b1, ref_bit(w, 4, b), (b == 0)});
        else n_pass++;
      end
    end
    n_checks++;
    if (ovf !== 1'b0)
      $display("FAIL rand_no_overflow: got %b want 0", ovf);
    else n_pass++;
  endtask

  task automatic test_overflow;
    logic [3:0] exp = 4'b1000;
    accept16(3, -3);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_checks++;
      if ({odv, obit} !== {1'b1, exp[3-b]})
        $display("FAIL ovf_bit%0d: dv/bit got %b want %b", b, {odv, obit}, {1'b1, exp[3-b]});
      else n_pass++;
      if (b == 1) begin
        n_checks++;
        if (ready !== 1'b0) $display("FAIL ovf_ready_low: got %b want 0", ready);
        else n_pass++;
        dv = 1'b1; si = -128; sq = 127;
      end
      if (b == 2) begin
        dv = 1'b0;
        n_checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf);
        else n_pass++;
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({odv, ovf} !== 2'b01)
      $display("FAIL ovf_sticky: dv/ovf got %b want 01", {odv, ovf});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    accept16(3, -3);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({odv, obit, sos, ovf, ready} !== 5'b00001)
      $display("FAIL rstmid_async: dv/bit/sos/ovf/ready got %b want 00001", {odv, obit, sos, ovf, ready});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", ready);
    else n_pass++;
    dv = 1'b1; si = 1; sq = 1;
    @(posedge clk);
    #1 dv = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_checks++;
      if ({odv, obit, sos} !== {2'b11, (b == 0)})
        $display("FAIL rstmid_bit%0d: dv/bit/sos got %b want %b", b, {odv, obit, sos}, {2'b11, (b == 0)});
      else n_pass++;
    end
  endtask

  task automatic test_m4;
    int xi, xq, w;
    accept4(5, -1);
    @(negedge clk);
    n_checks++;
    if ({odv4, obit4, sos4, ready4} !== 4'b1110)
      $display("FAIL m4_bit0: dv/bit/sos/ready got %b want 1110", {odv4, obit4, sos4, ready4});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({odv4, obit4, sos4, ready4} !== 4'b1001)
      $display("FAIL m4_bit1: dv/bit/sos/ready got %b want 1001", {odv4, obit4, sos4, ready4});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (odv4 !== 1'b0) $display("FAIL m4_idle: dv got %b want 0", odv4);
    else n_pass++;
    for (int n = 0; n < 10; n++) begin
      xi = $signed(8'($urandom));
      xq = int'($urandom_range(0, 6)) - 3;
      w  = ref_word(xi, xq, 2);
      accept4(xi, xq);
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        n_checks++;
        if ({odv4, obit4} !== {1'b1, ref_bit(w, 2, b)})
          $display("FAIL m4_rand_I%0d_Q%0d_bit%0d: got %b want %b", xi, xq, b, {odv4, obit4}, {1'b1, ref_bit(w, 2, b)});
        else n_pass++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_thresholds();
    test_back_to_back();
    test_random();
    test_m4();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
